fifo_stream_reader: RTL and testbench

//  Reader-side engine for the request/ready FIFOs (fifo, fifo_asymmetric): pops a programmed number of words,

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_skid_buffer.sv | 73 +++++++
 rtl/fifo_stream_reader.sv | 138 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants for the FIFO reader-side engine: FSM state
//            encodings and the depth of the output skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Reader FSM states, 2-bit encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Entries in the output skid buffer; two are enough to hide the
  // one-cycle read latency at full rate
  localparam int SKID_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_skid_buffer
// Purpose  : Two-entry register buffer with a valid/ready read side. The
//            head register drives the output directly, so read data is
//            always registered. The writer is trusted to respect occ.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_skid_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  w_pop;

  assign w_pop    = rd_valid && rd_ready;
  assign rd_valid = (r_occ != 2'd0);
  assign rd_data  = r_head;
  assign occ      = r_occ;

  // Head/tail shuffle: a simultaneous write and read keeps occupancy constant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (wr_valid) begin
            r_head <= wr_data;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && wr_valid) begin
            r_head <= wr_data;
          end else if (w_pop) begin
            r_occ  <= 2'd0;
          end else if (wr_valid) begin
            r_tail <= wr_data;
            r_occ  <= 2'(SKID_DEPTH);
          end
        end
        default: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (wr_valid) begin
              r_tail <= wr_data;
            end else begin
              r_occ  <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Pops a programmed number of words from a request/ready FIFO,
//            absorbs its one-cycle read latency and re-presents the words as
//            a valid/ready stream with a last flag, one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_read_req,
  input  logic                   fifo_read_ready,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  input  logic                   m_ready
);

  logic [1:0]             r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [COUNT_WIDTH-1:0] r_rem_issue;
  logic [COUNT_WIDTH-1:0] r_rem_out;
  logic                   r_inflight;
  logic [1:0]             w_occ;
  logic                   w_pop_out;
  logic                   w_pop_in;
  logic                   w_credit;
  logic [2:0]             w_committed;

  assign w_pop_out = m_valid && m_ready;

  // Words already owed to the buffer after this cycle; pop_out can never
  // exceed occ, so the subtraction cannot underflow
  assign w_committed = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop_out);
  assign w_credit    = (w_committed < 3'(SKID_DEPTH));

  assign fifo_read_req = (r_state == READ) && (r_rem_issue != '0) && w_credit;
  assign w_pop_in      = fifo_read_req && fifo_read_ready;

  assign busy   = r_busy;
  assign done   = r_done;
  assign m_last = m_valid && (r_rem_out == COUNT_WIDTH'(1));

  // Pop issued this cycle means read data arrives on the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop_in;
    end
  end

  // Remaining pops to issue and remaining words to hand downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem_issue <= '0;
      r_rem_out   <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_rem_issue <= num_words;
      r_rem_out   <= num_words;
    end else begin
      if (w_pop_in) begin
        r_rem_issue <= r_rem_issue - COUNT_WIDTH'(1);
      end
      if (w_pop_out) begin
        r_rem_out <= r_rem_out - COUNT_WIDTH'(1);
      end
    end
  end

  // Transfer sequencing with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (num_words != '0) begin
              r_state <= READ;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_rem_issue == '0) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the final word is accepted so done follows it directly
          if ((r_rem_out == '0) || (w_pop_out && (r_rem_out == COUNT_WIDTH'(1)))) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (r_inflight),
    .wr_data  (fifo_read_data),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .rd_ready (m_ready),
    .occ      (w_occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Scoreboard bench. A memory-backed FIFO model feeds the reader;
//            each transfer pushes the next N FIFO words into an expected
//            queue, and a negedge monitor checks every accepted word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW   = 64;
  localparam int CW   = 16;
  localparam int MEMD = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_words;
  logic          busy;
  logic          done;
  logic          fifo_read_req;
  logic          fifo_read_ready;
  logic [DW-1:0] fifo_read_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_words       (num_words),
    .busy            (busy),
    .done            (done),
    .fifo_read_req   (fifo_read_req),
    .fifo_read_ready (fifo_read_ready),
    .fifo_read_data  (fifo_read_data),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_last          (m_last),
    .m_ready         (m_ready)
  );

  // Upstream FIFO model: mem[rp..wp-1] holds the queued words
  logic [DW-1:0] mem [MEMD];
  int            wp = 0;
  int            rp = 0;
  logic          fifo_en;
  int            ready_mode;
  int            en_mode;

  assign fifo_read_ready = fifo_en && (wp != rp);

  // Pop returns data one cycle after the popping edge
  always @(posedge clk) begin
    if (!reset && fifo_read_req && fifo_read_ready) begin
      fifo_read_data <= mem[rp];
      rp             <= rp + 1;
    end
  end

  // Consumer ready and FIFO availability patterns
  initial begin
    m_ready = 1'b0;
    fifo_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(0, 99) < 60);
      endcase
      case (en_mode)
        0:       fifo_en = 1'b1;
        1:       fifo_en = ($urandom_range(0, 99) < 75);
        default: fifo_en = 1'b0;
      endcase
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    string         name;
    logic [DW-1:0] act;
    logic [DW-1:0] expv;
  } chk_t;

  exp_t exp_q[$];
  chk_t dq[$];

  int            n_vec    = 0;
  int            n_err    = 0;
  int            done_cnt = 0;
  logic          exp_done = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  exp_t          me;
  chk_t          mc;

  task automatic mon_cmp(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Monitor: drains direct checks, scoreboards accepted words, checks holds
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      mc = dq.pop_front();
      mon_cmp(mc.name, mc.act, mc.expv);
    end
    if (reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (exp_done) begin
        mon_cmp("done_after_last", 64'(done), 64'd1);
        exp_done = 1'b0;
      end
      if (prev_stall) begin
        mon_cmp("stall_valid", 64'(m_valid), 64'd1);
        mon_cmp("stall_data", m_data, prev_data);
        mon_cmp("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          mon_cmp("extra_word", m_data, 64'hDEAD_0000_0000_DEAD);
        end else begin
          me = exp_q.pop_front();
          mon_cmp("m_data", m_data, me.data);
          mon_cmp("m_last", 64'(m_last), 64'(me.last));
          if (me.last) exp_done = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic post(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    chk_t c;
    c.name = nm;
    c.act  = a;
    c.expv = e;
    dq.push_back(c);
  endtask

  int staged = 0;

  // Write words into the FIFO memory without making them visible yet
  task automatic stage_rand(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp + staged + i] = {$urandom, $urandom};
    end
    staged += n;
  endtask

  task automatic commit();
    wp     += staged;
    staged  = 0;
  endtask

  // One transfer: dup_at pulses a second start, fill_at delays FIFO fill
  task automatic run_xfer(input int n, input int dup_at, input int fill_at, input bit lat);
    int   d0;
    int   p0;
    int   cyc;
    int   first_v;
    int   last_v;
    exp_t e;
    p0      = rp;
    d0      = done_cnt;
    first_v = -1;
    last_v  = -1;
    for (int i = 0; i < n; i++) begin
      e.data = mem[p0 + i];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    start     = 1'b1;
    num_words = CW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (lat) post("lat_req_cycle1", 64'(fifo_read_req), 64'd1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (m_valid && first_v < 0) first_v = cyc + 1;
      if (m_valid && m_last)      last_v  = cyc + 1;
      if (cyc == fill_at) begin
        post("empty_busy", 64'(busy), 64'd1);
        post("empty_no_pop", 64'(rp - p0), 64'd0);
        commit();
      end
      if (cyc == dup_at) begin
        start     = 1'b1;
        num_words = CW'(9);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    post("xfer_in_budget", 64'(cyc < 3000), 64'd1);
    if (lat) begin
      post("lat_first_valid", 64'(first_v), 64'd3);
      post("burst_no_bubble", 64'(last_v - first_v), 64'(n - 1));
    end
    repeat (2) @(posedge clk);
    #1;
    post("done_pulses", 64'(done_cnt - d0), 64'd1);
    post("pop_count", 64'(rp - p0), 64'(n));
    post("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    ready_mode = 0;
    en_mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    post("rst_busy", 64'(busy), 64'd0);
    post("rst_done", 64'(done), 64'd0);
    post("rst_req", 64'(fifo_read_req), 64'd0);
    post("rst_valid", 64'(m_valid), 64'd0);
    post("rst_last", 64'(m_last), 64'd0);
    post("rst_data", m_data, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Four known words, full rate, latency and burst shape
    for (int i = 0; i < 4; i++) mem[wp + i] = 64'hA0 + 64'(i);
    wp += 4;
    run_xfer(4, -1, -1, 1'b1);

    // Zero-length transfer: FINISH straight away, no pops
    start     = 1'b1;
    num_words = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    post("zero_done_c1", 64'(done), 64'd1);
    post("zero_busy_c1", 64'(busy), 64'd1);
    post("zero_no_req", 64'(fifo_read_req), 64'd0);
    @(posedge clk);
    #1;
    post("zero_done_c2", 64'(done), 64'd0);
    post("zero_busy_c2", 64'(busy), 64'd0);

    // Toggling backpressure
    ready_mode = 1;
    stage_rand(8);
    commit();
    run_xfer(8, -1, -1, 1'b0);

    // Empty FIFO for ten cycles, then filled
    ready_mode = 0;
    stage_rand(3);
    run_xfer(3, -1, 10, 1'b0);

    // Reset in the middle of a transfer
    ready_mode = 2;
    stage_rand(16);
    commit();
    for (int i = 0; i < 16; i++) begin
      me.data = mem[rp + i];
      me.last = (i == 15);
      exp_q.push_back(me);
    end
    start     = 1'b1;
    num_words = CW'(16);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    post("midrst_busy", 64'(busy), 64'd0);
    post("midrst_done", 64'(done), 64'd0);
    post("midrst_req", 64'(fifo_read_req), 64'd0);
    post("midrst_valid", 64'(m_valid), 64'd0);
    post("midrst_data", m_data, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_xfer(2, -1, -1, 1'b0);

    // Second start while busy must be ignored
    ready_mode = 0;
    stage_rand(5);
    commit();
    run_xfer(5, 2, -1, 1'b0);

    // Randomized transfers under random backpressure and FIFO stalls
    for (int t = 0; t < 10; t++) begin
      int n;
      n          = $urandom_range(1, 24);
      ready_mode = $urandom_range(0, 2);
      en_mode    = $urandom_range(0, 1);
      stage_rand(n);
      commit();
      run_xfer(n, -1, -1, 1'b0);
    end
    en_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
